led_sched: RTL and testbench
============================

Name: led_sched

Overview:
- Time-multiplexes the two board LEDs between NUM_REQ requesters: status sources, button handlers and error flags.
- Each requester asks for a blink pattern through a req/grant/done handshake.
- A round-robin arbiter picks the next pattern; a tick-based sequencer plays it.
- When no pattern is running, the block drives a heartbeat on led[0].
- Sits between the board pins and the rest of the top level, and replaces ad-hoc per-module LED counters.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- TICK_DIV, 50000: clk cycles per tick (1 ms at 50 MHz).
- ON_TICKS, 150: ticks LED is lit per blink.
- OFF_TICKS, 150: ticks LED is dark per blink; also the post-pattern gap length.
- SOLID_TICKS, 1000: ticks lit for a solid (blinks==0) request.
- HB_TICKS, 500: heartbeat half-period in ticks.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- req, input, NUM_REQ: request level per requester.
- req_mask, input, 2*NUM_REQ: LED select per requester; bits [2i+1:2i].
- req_blinks, input, 4*NUM_REQ: blink count per requester; bits [4i+3:4i]; 0 = solid.
- grant, output, NUM_REQ: one-cycle one-hot pulse; pattern accepted.
- done, output, NUM_REQ: one-cycle pulse; pattern finished.
- busy, output, 1: high whenever state != IDLE.
- led, output, 2: LED drive; active-low, 1 = off.

Behaviour:
- Reset values: led=2'b11, grant=0, done=0, busy=0; state=IDLE; rr pointer=0; tick divider, phase counter and heartbeat counter all 0.
- Tick: free-running divider counts 0..TICK_DIV-1; tick strobe on the wrap. Divider clears on every grant so pattern phases are tick-exact.
- States: IDLE, ON, OFF, GAP.
- IDLE:
  - led[1]=1; led[0] toggles every HB_TICKS ticks.
  - If any req bit is set, grant the first set bit at or after the rr pointer, wrapping (round-robin).
  - On the grant cycle, latch that requester's mask and blinks, set rr pointer = winner+1 mod NUM_REQ, and pulse grant[winner].
  - Next state is ON; phase counter loads SOLID_TICKS if blinks==0, else ON_TICKS.
  - Heartbeat counter freezes while not in IDLE and resumes on return; the led[0] heartbeat level is restored on return.
- ON: led = ~mask (masked LEDs lit, others off). On phase count expiry:
  - solid request -> GAP, and pulse done;
  - else -> OFF with OFF_TICKS.
- OFF: led=2'b11. On expiry, decrement the blink counter:
  - counter now 0 -> GAP, and pulse done;
  - else -> ON.
- GAP: led=2'b11 for OFF_TICKS, then IDLE. No arbitration during GAP.
- Timing: done pulses on the cycle GAP is entered. The earliest re-grant is the cycle after GAP expiry.
- No preemption: a running pattern always completes.
- Requesters must drop req on or before the cycle after grant. A req still high after that is treated as a new request and re-arbitrates normally.
- mask==2'b00: pattern is timed identically with no visible LED; grant and done are still issued.
- Simultaneous requests: only one grant per arbitration. Losers keep req high and are served in rr order, so there is no starvation.
- Reset mid-pattern: abort immediately to reset values. No done pulse is issued for the aborted pattern.
- Width rules:
  - phase counter width = clog2(max(ON_TICKS, OFF_TICKS, SOLID_TICKS)+1);
  - heartbeat counter width = clog2(HB_TICKS+1);
  - blink counter is 4 bits, max 15 blinks.

Decomposition:
- Package led_sched_pkg:
  - state enum (IDLE, ON, OFF, GAP);
  - LED_OFF = 2'b11;
  - BLINK_W = 4;
  - MASK_W = 2.
- One sub-module, rr_arbiter:
  - parameter N;
  - inputs req, ptr, en;
  - outputs one-hot gnt and the winner index;
  - purely combinational, with the pointer register kept in led_sched.

Test Plan (TICK_DIV=4, ON=2, OFF=2, SOLID=5, HB=3):
- Idle after reset: no req -> led[1]=1 constant; led[0] toggles every 12 clk; busy=0.
- Single blink: req[1], mask 01, blinks 2:
  - grant[1] next cycle;
  - led[0]=0 for 8 clk, 1 for 8, 0 for 8, 1 for 8;
  - done[1] then led=11 for 8 clk; then busy=0.
- Solid: req[0], mask 11, blinks 0 -> led=00 for exactly 20 clk, then done[0], an 8-clk gap, and idle.
- Contention: req=1111 held with rr pointer 0 -> grants in order 0,1,2,3,0; each grant only after the previous done plus the gap.
- Reset mid-pattern: reset during ON -> next cycle led=11, busy=0, grant and done 0, and no done pulse for the aborted pattern.
- Late req drop: req[2] held 1 through done -> a second grant[2] is issued after the gap with the same timing.

Source files
------------

// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED pattern scheduler.
package led_sched_pkg;

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  localparam logic [1:0]  LED_OFF = 2'b11;
  localparam int unsigned BLINK_W = 4;
  localparam int unsigned MASK_W  = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/led_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] winner
);

  int unsigned   k;
  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    k      = 0;
    cand   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k    = (32'(ptr) + i) % N;
      cand = IW'(k);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        winner    = cand;
      end
    end
  end

endmodule

// File: rtl/led_sched.sv
// Round-robin LED pattern scheduler with tick-based blink sequencer and idle heartbeat.
module led_sched
  import led_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned ON_TICKS    = 150,
  parameter int unsigned OFF_TICKS   = 150,
  parameter int unsigned SOLID_TICKS = 1000,
  parameter int unsigned HB_TICKS    = 500
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [MASK_W*NUM_REQ-1:0]   req_mask,
  input  logic [BLINK_W*NUM_REQ-1:0]  req_blinks,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          done,
  output logic                        busy,
  output logic [1:0]                  led
);

  localparam int unsigned IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DIV_W = $clog2(TICK_DIV + 1);
  localparam int unsigned PH_W  = $clog2(max3(ON_TICKS, OFF_TICKS, SOLID_TICKS) + 1);
  localparam int unsigned HB_W  = $clog2(HB_TICKS + 1);

  state_t               state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        cur_idx;
  logic [MASK_W-1:0]    cur_mask;
  logic [BLINK_W-1:0]   blink_cnt;
  logic [DIV_W-1:0]     tick_cnt;
  logic [PH_W-1:0]      phase;
  logic [HB_W-1:0]      hb_cnt;
  logic                 hb_lvl;

  logic [MASK_W-1:0]    mask_arr  [NUM_REQ];
  logic [BLINK_W-1:0]   blink_arr [NUM_REQ];
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_winner;
  logic                 tick;
  logic                 expire;
  logic                 hb_wrap;
  logic                 hb_next;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign mask_arr[g]  = req_mask[MASK_W*g +: MASK_W];
    assign blink_arr[g] = req_blinks[BLINK_W*g +: BLINK_W];
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req    (req),
    .ptr    (ptr),
    .en     (state == IDLE),
    .gnt    (arb_gnt),
    .winner (arb_winner)
  );

  always_comb begin
    tick    = (tick_cnt == DIV_W'(TICK_DIV - 1));
    expire  = tick && (phase == PH_W'(1));
    hb_wrap = tick && (hb_cnt == HB_W'(HB_TICKS - 1));
    hb_next = hb_wrap ? ~hb_lvl : hb_lvl;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cur_idx   <= '0;
      cur_mask  <= '0;
      blink_cnt <= '0;
      tick_cnt  <= '0;
      phase     <= '0;
      hb_cnt    <= '0;
      hb_lvl    <= 1'b1;
      led       <= LED_OFF;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
    end else begin
      grant    <= '0;
      done     <= '0;
      tick_cnt <= tick ? '0 : tick_cnt + DIV_W'(1);
      unique case (state)
        IDLE: begin
          if (tick) begin
            hb_cnt <= hb_wrap ? '0 : hb_cnt + HB_W'(1);
            hb_lvl <= hb_next;
          end
          led <= {1'b1, hb_next};
          // Grant overrides the heartbeat drive; the divider restarts so ON is tick-exact.
          if (|arb_gnt) begin
            grant     <= arb_gnt;
            cur_idx   <= arb_winner;
            cur_mask  <= mask_arr[arb_winner];
            blink_cnt <= blink_arr[arb_winner];
            ptr       <= (arb_winner == IW'(NUM_REQ - 1)) ? '0 : arb_winner + IW'(1);
            phase     <= (blink_arr[arb_winner] == '0) ? PH_W'(SOLID_TICKS) : PH_W'(ON_TICKS);
            tick_cnt  <= '0;
            led       <= ~mask_arr[arb_winner];
            busy      <= 1'b1;
            state     <= ON;
          end
        end
        ON: begin
          if (expire) begin
            led   <= LED_OFF;
            phase <= PH_W'(OFF_TICKS);
            if (blink_cnt == '0) begin
              done[cur_idx] <= 1'b1;
              state         <= GAP;
            end else begin
              state <= OFF;
            end
          end else if (tick) begin
            phase <= phase - PH_W'(1);
          end
        end
        OFF: begin
          if (expire) begin
            blink_cnt <= blink_cnt - BLINK_W'(1);
            if (blink_cnt == BLINK_W'(1)) begin
              phase         <= PH_W'(OFF_TICKS);
              done[cur_idx] <= 1'b1;
              state         <= GAP;
            end else begin
              phase <= PH_W'(ON_TICKS);
              led   <= ~cur_mask;
              state <= ON;
            end
          end else if (tick) begin
            phase <= phase - PH_W'(1);
          end
        end
        GAP: begin
          if (expire) begin
            led   <= {1'b1, hb_lvl};
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tick) begin
            phase <= phase - PH_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_sched.sv
// Directed self-checking bench for led_sched with small tick parameters.
module tb_led_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  req_mask;
  logic [15:0] req_blinks;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [1:0]  led;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_sched #(
    .NUM_REQ(4), .TICK_DIV(4), .ON_TICKS(2), .OFF_TICKS(2),
    .SOLID_TICKS(5), .HB_TICKS(3)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_mask(req_mask),
    .req_blinks(req_blinks), .grant(grant), .done(done), .busy(busy), .led(led)
  );

  task automatic test_reset();
    reset = 1'b1; req = '0; req_mask = '0; req_blinks = '0;
    repeat (3) @(negedge clk);
    total++;
    if (led !== 2'b11 || grant !== 4'b0 || done !== 4'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: led=%b grant=%b done=%b busy=%b want 11/0000/0000/0", led, grant, done, busy);
    end
  endtask

  task automatic test_heartbeat();
    logic exp0;
    reset = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      exp0 = ((k / 12) % 2 == 0);
      total++;
      if (led !== {1'b1, exp0} || busy !== 1'b0) begin
        bad++;
        $display("FAIL heartbeat k=%0d: led=%b busy=%b want %b/0", k, led, busy, {1'b1, exp0});
      end
    end
  endtask

  task automatic test_single_blink();
    logic [1:0] el;
    req = 4'b0010; req_mask = 8'h04; req_blinks = 16'h0020;
    for (int s = 1; s <= 41; s++) begin
      @(negedge clk);
      el = ((s <= 8) || (s >= 17 && s <= 24)) ? 2'b10 : 2'b11;
      total++;
      if (s <= 40) begin
        if (led !== el || busy !== 1'b1 || grant !== ((s == 1) ? 4'b0010 : 4'b0) ||
            done !== ((s == 33) ? 4'b0010 : 4'b0)) begin
          bad++;
          $display("FAIL single_blink s=%0d: led=%b busy=%b grant=%b done=%b want led=%b", s, led, busy, grant, done, el);
        end
      end else if (led[1] !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL single_blink_idle: led=%b busy=%b want 1x/0", led, busy);
      end
      if (s == 1) req = '0;
    end
  endtask

  task automatic test_solid();
    req = 4'b0001; req_mask = 8'h03; req_blinks = 16'h0000;
    for (int s = 1; s <= 29; s++) begin
      @(negedge clk);
      total++;
      if (s <= 28) begin
        if (led !== ((s <= 20) ? 2'b00 : 2'b11) || busy !== 1'b1 ||
            grant !== ((s == 1) ? 4'b0001 : 4'b0) || done !== ((s == 21) ? 4'b0001 : 4'b0)) begin
          bad++;
          $display("FAIL solid s=%0d: led=%b busy=%b grant=%b done=%b", s, led, busy, grant, done);
        end
      end else if (busy !== 1'b0) begin
        bad++;
        $display("FAIL solid_idle: busy=%b want 0", busy);
      end
      if (s == 1) req = '0;
    end
  endtask

  task automatic test_mask_zero();
    int w;
    req = 4'b1000; req_mask = 8'h00; req_blinks = 16'h1000;
    @(negedge clk);
    req = '0;
    total++;
    if (grant !== 4'b1000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mask_zero_grant: grant=%b busy=%b want 1000/1", grant, busy);
    end
    w = 0;
    while (done === 4'b0 && w < 60) begin
      @(negedge clk); w++;
      total++;
      if (led !== 2'b11) begin
        bad++;
        $display("FAIL mask_zero_led: led=%b want 11", led);
      end
    end
    total++;
    if (w != 16 || done !== 4'b1000) begin
      bad++;
      $display("FAIL mask_zero_done: cycles=%0d done=%b want 16/1000", w, done);
    end
    w = 0;
    while (busy === 1'b1 && w < 60) begin @(negedge clk); w++; end
    total++;
    if (w != 8) begin
      bad++;
      $display("FAIL mask_zero_gap: cycles=%0d want 8", w);
    end
  endtask

  task automatic test_contention();
    int w;
    int exp_idx;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    req = 4'b1111; req_mask = 8'h55; req_blinks = 16'h1111;
    for (int n = 0; n < 5; n++) begin
      exp_idx = n % 4;
      w = 0;
      while (grant === 4'b0 && w < 60) begin @(negedge clk); w++; end
      total++;
      if (grant !== (4'b1 << exp_idx) || w != ((n == 0) ? 1 : 9)) begin
        bad++;
        $display("FAIL contention_grant n=%0d: grant=%b wait=%0d want %b/%0d", n, grant, w,
                 4'b1 << exp_idx, (n == 0) ? 1 : 9);
      end
      if (n == 4) req = '0;
      w = 0;
      while (done === 4'b0 && w < 60) begin @(negedge clk); w++; end
      total++;
      if (done !== (4'b1 << exp_idx) || w != 16) begin
        bad++;
        $display("FAIL contention_done n=%0d: done=%b wait=%0d want %b/16", n, done, w, 4'b1 << exp_idx);
      end
    end
    w = 0;
    while (busy === 1'b1 && w < 60) begin @(negedge clk); w++; end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL contention_end: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic stray;
    req = 4'b0100; req_mask = 8'h30; req_blinks = 16'h0300;
    @(negedge clk);
    req = '0;
    total++;
    if (grant !== 4'b0100 || led !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid_grant: grant=%b led=%b want 0100/00", grant, led);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (led !== 2'b11 || busy !== 1'b0 || grant !== 4'b0 || done !== 4'b0) begin
      bad++;
      $display("FAIL reset_mid_abort: led=%b busy=%b grant=%b done=%b want 11/0/0000/0000", led, busy, grant, done);
    end
    reset = 1'b0;
    stray = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done !== 4'b0 || busy !== 1'b0) stray = 1'b1;
    end
    total++;
    if (stray !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_no_done: stray=%b want 0", stray);
    end
  endtask

  task automatic test_late_drop();
    int w;
    req = 4'b0100; req_mask = 8'h20; req_blinks = 16'h0100;
    @(negedge clk);
    total++;
    if (grant !== 4'b0100 || led !== 2'b01) begin
      bad++;
      $display("FAIL late_drop_grant1: grant=%b led=%b want 0100/01", grant, led);
    end
    w = 0;
    while (done === 4'b0 && w < 60) begin @(negedge clk); w++; end
    total++;
    if (done !== 4'b0100 || w != 16) begin
      bad++;
      $display("FAIL late_drop_done1: done=%b wait=%0d want 0100/16", done, w);
    end
    w = 0;
    while (grant === 4'b0 && w < 60) begin @(negedge clk); w++; end
    req = '0;
    total++;
    if (grant !== 4'b0100 || w != 9) begin
      bad++;
      $display("FAIL late_drop_grant2: grant=%b wait=%0d want 0100/9", grant, w);
    end
    w = 0;
    while (done === 4'b0 && w < 60) begin @(negedge clk); w++; end
    total++;
    if (done !== 4'b0100 || w != 16) begin
      bad++;
      $display("FAIL late_drop_done2: done=%b wait=%0d want 0100/16", done, w);
    end
    w = 0;
    while (busy === 1'b1 && w < 60) begin @(negedge clk); w++; end
    total++;
    if (w != 8) begin
      bad++;
      $display("FAIL late_drop_gap: cycles=%0d want 8", w);
    end
  endtask

  initial begin
    test_reset();
    test_heartbeat();
    test_single_blink();
    test_solid();
    test_mask_zero();
    test_contention();
    test_reset_mid();
    test_late_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
